// File: rtl/dma_burst_engine.sv
// Single-shot DMA between DDR (AXI4 master) and SPM, split into INCR bursts that never cross 4 KiB.
// Reads stream R beats straight into SPM; writes prefetch SPM words through a 2-entry FIFO.
module dma_burst_engine #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int SPM_ADDR_WIDTH = 16,
  parameter int MAX_BURST_LEN  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        axi_rd_start,
  input  logic                        axi_wr_start,
  input  logic [10:0]                 poly_id_i,
  input  logic [63:0]                 base_addr,
  input  logic [63:0]                 data_ptr,
  input  logic [31:0]                 data_size_bytes,
  output logic                        axi_rd_done,
  output logic                        axi_wr_done,
  output logic [10:0]                 poly_id_o,
  output logic                        dma_err,
  output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic [SPM_ADDR_WIDTH-1:0]   spm_addr,
  output logic                        spm_we,
  output logic [AXI_DATA_WIDTH-1:0]   spm_wdata,
  output logic                        spm_re,
  input  logic [AXI_DATA_WIDTH-1:0]   spm_rdata
);
  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_LEN);
  localparam logic [AXI_ADDR_WIDTH-1:0] AMASK = AXI_ADDR_WIDTH'(BPB - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_AR   = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_AW   = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;

  logic [2:0]                state;
  logic [AXI_ADDR_WIDTH-1:0] ddr_addr;
  logic [SPM_ADDR_WIDTH-1:0] spm_ptr;
  logic [31:0]               remaining;
  logic [31:0]               beats_in;
  logic [31:0]               to_bound;
  logic [31:0]               burst_len;
  logic [8:0]                cur_len;
  logic [8:0]                rd_cnt;
  logic [8:0]                w_cnt;
  logic [10:0]               tag;
  logic                      w_fire;

  logic [AXI_DATA_WIDTH-1:0] fifo_mem [2];
  logic                      fifo_wp;
  logic                      fifo_rp;
  logic [1:0]                fifo_cnt;
  logic                      rd_pend;

  logic unused_ok;
  assign unused_ok = ^base_addr[63:SPM_ADDR_WIDTH];

  assign beats_in = data_size_bytes >> SZ;

  always_comb begin
    to_bound  = (32'd4096 - {20'd0, ddr_addr[11:0]}) >> SZ;
    burst_len = remaining;
    if (burst_len > MAX_LEN)  burst_len = MAX_LEN;
    if (burst_len > to_bound) burst_len = to_bound;
  end

  assign m_araddr  = ddr_addr;
  assign m_arlen   = 8'(burst_len - 32'd1);
  assign m_arsize  = 3'(SZ);
  assign m_arburst = 2'b01;
  assign m_arvalid = (state == RD_AR);
  assign m_rready  = (state == RD_DATA);

  assign m_awaddr  = ddr_addr;
  assign m_awlen   = 8'(burst_len - 32'd1);
  assign m_awsize  = 3'(SZ);
  assign m_awburst = 2'b01;
  assign m_awvalid = (state == WR_AW);
  assign m_bready  = (state == WR_RESP);

  assign m_wvalid = (fifo_cnt != 2'd0);
  assign m_wdata  = fifo_mem[fifo_rp];
  assign m_wstrb  = '1;
  assign m_wlast  = m_wvalid && (w_cnt == cur_len - 9'd1);
  assign w_fire   = m_wvalid && m_wready;

  // Occupancy counts the beat leaving this cycle so a full-rate wready sees no bubbles.
  assign spm_re    = (state == WR_DATA) && (rd_cnt < cur_len) &&
                     ((3'(fifo_cnt) + 3'(rd_pend) - 3'(w_fire)) < 3'd2);
  assign spm_we    = (state == RD_DATA) && m_rvalid;
  assign spm_wdata = m_rdata;
  assign spm_addr  = spm_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ddr_addr    <= '0;
      spm_ptr     <= '0;
      remaining   <= '0;
      cur_len     <= '0;
      rd_cnt      <= '0;
      w_cnt       <= '0;
      tag         <= '0;
      axi_rd_done <= 1'b0;
      axi_wr_done <= 1'b0;
      poly_id_o   <= '0;
      dma_err     <= 1'b0;
    end else begin
      if (spm_re) begin
        spm_ptr <= spm_ptr + SPM_ADDR_WIDTH'(1);
        rd_cnt  <= rd_cnt + 9'd1;
      end
      if (w_fire) w_cnt <= w_cnt + 9'd1;
      case (state)
        IDLE: begin
          if (axi_rd_start || axi_wr_start) begin
            ddr_addr  <= data_ptr[AXI_ADDR_WIDTH-1:0] & ~AMASK;
            spm_ptr   <= base_addr[SPM_ADDR_WIDTH-1:0];
            remaining <= beats_in;
            dma_err   <= 1'b0;
          end
          if (axi_rd_start) begin
            tag <= poly_id_i;
            if (beats_in == 32'd0) begin
              axi_rd_done <= 1'b1;
              poly_id_o   <= poly_id_i;
            end else begin
              axi_rd_done <= 1'b0;
              state       <= RD_AR;
            end
          end else if (axi_wr_start) begin
            if (beats_in == 32'd0) begin
              axi_wr_done <= 1'b1;
            end else begin
              axi_wr_done <= 1'b0;
              state       <= WR_AW;
            end
          end
        end
        RD_AR: if (m_arready) begin
          ddr_addr  <= ddr_addr + AXI_ADDR_WIDTH'(burst_len << SZ);
          remaining <= remaining - burst_len;
          state     <= RD_DATA;
        end
        RD_DATA: if (m_rvalid) begin
          spm_ptr <= spm_ptr + SPM_ADDR_WIDTH'(1);
          if (m_rresp != 2'b00) dma_err <= 1'b1;
          if (m_rlast) begin
            if (remaining == 32'd0) begin
              state       <= IDLE;
              axi_rd_done <= 1'b1;
              poly_id_o   <= tag;
            end else begin
              state <= RD_AR;
            end
          end
        end
        WR_AW: if (m_awready) begin
          ddr_addr  <= ddr_addr + AXI_ADDR_WIDTH'(burst_len << SZ);
          remaining <= remaining - burst_len;
          cur_len   <= 9'(burst_len);
          rd_cnt    <= '0;
          w_cnt     <= '0;
          state     <= WR_DATA;
        end
        WR_DATA: if (w_fire && m_wlast) state <= WR_RESP;
        WR_RESP: if (m_bvalid) begin
          if (m_bresp != 2'b00) dma_err <= 1'b1;
          if (remaining == 32'd0) begin
            state       <= IDLE;
            axi_wr_done <= 1'b1;
          end else begin
            state <= WR_AW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SPM data lands one cycle after spm_re, tracked by rd_pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= spm_re;
      if (rd_pend) fifo_wp <= ~fifo_wp;
      if (w_fire)  fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(rd_pend) - 2'(w_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_pend) fifo_mem[fifo_wp] <= spm_rdata;
  end
endmodule
